// File: rtl/ifu_fetch.sv
// Instruction fetch initiator: sequential PC generation, one in-flight RAM read,
// small output FIFO toward decode, and redirect handling.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h8000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        imem_ren,
   output logic [31:0] imem_raddr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          inflight_q, inflight_d;
   logic [31:0]   inflight_pc_q, inflight_pc_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
   logic [31:0]   fifo_inst_q [FIFO_DEPTH];

   logic          pop;
   logic          push;
   logic [CW:0]   occupancy;

   // Occupancy counts the slot already promised to the in-flight read, so the
   // FIFO can never overflow when that response lands.
   always_comb begin
      out_valid  = (count_q != '0) & ~redirect_valid;
      pop        = out_valid & out_ready;
      push       = inflight_q & ~redirect_valid;
      occupancy  = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
      imem_ren   = reset_n & (redirect_valid | (occupancy < (CW+1)'(FIFO_DEPTH)));
      imem_raddr = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : fetch_pc_q;

      out_pc   = (count_q != '0) ? fifo_pc_q[rd_ptr_q]   : 32'h0;
      out_inst = (count_q != '0) ? fifo_inst_q[rd_ptr_q] : 32'h0;

      fetch_pc_d    = imem_ren ? imem_raddr + 32'd4 : fetch_pc_q;
      inflight_d    = imem_ren;
      inflight_pc_d = imem_ren ? imem_raddr : inflight_pc_q;

      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (redirect_valid) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= 32'h0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible through count_q.
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
         fifo_inst_q[wr_ptr_q] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch; the RAM model returns word[a]=a one cycle
// after each request and a marker value otherwise.
module tb_ifu_fetch;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        imem_ren;
   logic [31:0] imem_raddr;
   logic [31:0] imem_rdata = 32'hDEAD_BEEF;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   ifu_fetch #(
      .RESET_PC  (32'h8000_0000),
      .FIFO_DEPTH(2)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .imem_ren      (imem_ren),
      .imem_raddr    (imem_raddr),
      .imem_rdata    (imem_rdata),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_pc        (out_pc),
      .out_inst      (out_inst)
   );

   always @(posedge clock) imem_rdata <= imem_ren ? imem_raddr : 32'hDEAD_BEEF;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic rv, input logic [31:0] rpc, input logic rdy);
      @(negedge clock);
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
      #1;
   endtask

   task automatic release_reset(input logic rdy);
      @(negedge clock);
      reset_n        = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      out_ready      = rdy;
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clock);
      reset_n        = 1'b0;
      redirect_valid = 1'b0;
      out_ready      = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   task automatic expect_fetch(input string tag, input logic ren, input logic [31:0] addr);
      check({tag, ".ren"}, 32'(imem_ren), 32'(ren));
      if (ren) check({tag, ".raddr"}, imem_raddr, addr);
   endtask

   task automatic expect_out(input string tag, input logic vld, input logic [31:0] pc);
      check({tag, ".valid"}, 32'(out_valid), 32'(vld));
      if (vld) begin
         check({tag, ".pc"}, out_pc, pc);
         check({tag, ".inst"}, out_inst, pc);
      end
   endtask

   initial begin
      reset_n        = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      out_ready      = 1'b0;

      // reset state
      @(negedge clock);
      #1;
      check("rst.ren",   32'(imem_ren),  32'h0);
      check("rst.valid", 32'(out_valid), 32'h0);
      check("rst.pc",    out_pc,         32'h0);
      check("rst.inst",  out_inst,       32'h0);

      // streaming from reset, decode always ready
      release_reset(1'b1);
      expect_fetch("t1.c0", 1'b1, 32'h8000_0000);
      expect_out  ("t1.c0", 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b1);
      expect_fetch("t1.c1", 1'b1, 32'h8000_0004);
      expect_out  ("t1.c1", 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 32'h0, 1'b1);
         expect_fetch($sformatf("t1.s%0d", i), 1'b1, 32'h8000_0008 + 32'(4 * i));
         expect_out  ($sformatf("t1.s%0d", i), 1'b1, 32'h8000_0000 + 32'(4 * i));
      end

      // decode stall for 5 cycles starting at the first instruction
      apply_reset();
      release_reset(1'b0);
      expect_fetch("t2.c0", 1'b1, 32'h8000_0000);
      cyc(1'b0, 32'h0, 1'b0);
      expect_fetch("t2.c1", 1'b1, 32'h8000_0004);
      expect_out  ("t2.c1", 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 32'h0, 1'b0);
         expect_fetch($sformatf("t2.stall%0d", i), 1'b0, 32'h0);
         expect_out  ($sformatf("t2.stall%0d", i), 1'b1, 32'h8000_0000);
      end
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 32'h0, 1'b1);
         expect_fetch($sformatf("t2.go%0d", i), 1'b1, 32'h8000_0008 + 32'(4 * i));
         expect_out  ($sformatf("t2.go%0d", i), 1'b1, 32'h8000_0000 + 32'(4 * i));
      end

      // redirect while the FIFO is full
      apply_reset();
      release_reset(1'b0);
      cyc(1'b0, 32'h0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0);
      expect_out  ("t3.full", 1'b1, 32'h8000_0000);
      cyc(1'b1, 32'h8000_0103, 1'b1);
      expect_fetch("t3.redir", 1'b1, 32'h8000_0100);
      expect_out  ("t3.redir", 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b1);
      expect_fetch("t3.r1", 1'b1, 32'h8000_0104);
      expect_out  ("t3.r1", 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b1);
      expect_fetch("t3.r2", 1'b1, 32'h8000_0108);
      expect_out  ("t3.r2", 1'b1, 32'h8000_0100);
      cyc(1'b0, 32'h0, 1'b1);
      expect_out  ("t3.r3", 1'b1, 32'h8000_0104);

      // back-to-back redirects, second discards the first one's in-flight word
      cyc(1'b1, 32'h0000_1000, 1'b1);
      expect_fetch("t4.a", 1'b1, 32'h0000_1000);
      expect_out  ("t4.a", 1'b0, 32'h0);
      cyc(1'b1, 32'h0000_2000, 1'b1);
      expect_fetch("t4.b", 1'b1, 32'h0000_2000);
      expect_out  ("t4.b", 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b1);
      expect_fetch("t4.c", 1'b1, 32'h0000_2004);
      expect_out  ("t4.c", 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 32'h0, 1'b1);
         expect_out($sformatf("t4.d%0d", i), 1'b1, 32'h0000_2000 + 32'(4 * i));
      end

      // address wrap at the top of the space
      cyc(1'b1, 32'hFFFF_FFF8, 1'b1);
      expect_fetch("t5.redir", 1'b1, 32'hFFFF_FFF8);
      cyc(1'b0, 32'h0, 1'b1);
      expect_fetch("t5.r1", 1'b1, 32'hFFFF_FFFC);
      expect_out  ("t5.r1", 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b1);
      expect_fetch("t5.r2", 1'b1, 32'h0000_0000);
      expect_out  ("t5.r2", 1'b1, 32'hFFFF_FFF8);
      cyc(1'b0, 32'h0, 1'b1);
      expect_out  ("t5.r3", 1'b1, 32'hFFFF_FFFC);
      cyc(1'b0, 32'h0, 1'b1);
      expect_out  ("t5.r4", 1'b1, 32'h0000_0000);
      cyc(1'b0, 32'h0, 1'b1);
      expect_out  ("t5.r5", 1'b1, 32'h0000_0004);

      // asynchronous reset mid-stream with a read in flight
      @(negedge clock);
      #2;
      check("t6.pre.valid", 32'(out_valid), 32'h1);
      reset_n = 1'b0;
      #1;
      check("t6.async.ren",   32'(imem_ren),  32'h0);
      check("t6.async.valid", 32'(out_valid), 32'h0);
      check("t6.async.pc",    out_pc,         32'h0);
      @(posedge clock);
      release_reset(1'b1);
      expect_fetch("t6.c0", 1'b1, 32'h8000_0000);
      expect_out  ("t6.c0", 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b1);
      expect_fetch("t6.c1", 1'b1, 32'h8000_0004);
      expect_out  ("t6.c1", 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b1);
      expect_out  ("t6.c2", 1'b1, 32'h8000_0000);
      cyc(1'b0, 32'h0, 1'b1);
      expect_out  ("t6.c3", 1'b1, 32'h8000_0004);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
